// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: command bytes, counter widths, host-transmit state type
// and the frame builder used by the transmitter.
package ps2_pkg;

   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_SETRATE = 8'hF3;
   localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

   localparam int INH_CNT_W = 10;
   localparam int TO_CNT_W  = 17;
   localparam int FRAME_W   = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_BITS,
      ST_ACK,
      ST_WAITREL,
      ST_ERR
   } ps2_tx_state_t;

   // Bits shifted out after the start bit: data LSB first, odd parity, stop.
   function automatic logic [FRAME_W-1:0] ps2_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for one PS/2 line plus a registered-history falling-edge flag.
// Flops reset to 1 so an idle (pulled-up) bus never produces a spurious edge.
module ps2_sync (
   input  logic clk_sys,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic fall
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
         prev_reg <= 1'b1;
      end else begin
         meta_reg <= din;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign level = sync_reg;
   assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked data bits,
// ACK check and timeout supervision on an open-collector clock/data pair.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_TICKS = 720,
   parameter int TIMEOUT_TICKS = 90000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce_6mp,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_out,
   output logic       ps2_data_out,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       busy,
   output logic       tx_ack,
   output logic       tx_err
);

   localparam logic [INH_CNT_W-1:0] INH_LAST = INH_CNT_W'(INHIBIT_TICKS - 1);
   localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TIMEOUT_TICKS - 1);

   // Index 0 = bus clock, index 1 = bus data.
   logic [1:0] line_in;
   logic [1:0] line_sync;
   logic [1:0] line_fall;

   assign line_in = {ps2_data_in, ps2_clk_in};

   for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      ps2_sync u_sync (
         .clk_sys (clk_sys),
         .reset   (reset),
         .din     (line_in[gi]),
         .level   (line_sync[gi]),
         .fall    (line_fall[gi])
      );
   end

   logic clk_sync;
   logic data_sync;
   logic clk_fall;
   logic unused_data_fall;

   assign clk_sync         = line_sync[0];
   assign data_sync        = line_sync[1];
   assign clk_fall         = line_fall[0];
   assign unused_data_fall = line_fall[1];

   ps2_tx_state_t        state_reg,    state_next;
   logic [FRAME_W-1:0]   shift_reg,    shift_next;
   logic [3:0]           bit_cnt_reg,  bit_cnt_next;
   logic [INH_CNT_W-1:0] inh_cnt_reg,  inh_cnt_next;
   logic [TO_CNT_W-1:0]  to_cnt_reg,   to_cnt_next;
   logic                 clk_out_reg,  clk_out_next;
   logic                 data_out_reg, data_out_next;
   logic                 busy_reg,     busy_next;
   logic                 ack_reg,      ack_next;
   logic                 err_reg,      err_next;
   logic                 supervised;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         inh_cnt_reg  <= '0;
         to_cnt_reg   <= '0;
         clk_out_reg  <= 1'b1;
         data_out_reg <= 1'b1;
         busy_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         inh_cnt_reg  <= inh_cnt_next;
         to_cnt_reg   <= to_cnt_next;
         clk_out_reg  <= clk_out_next;
         data_out_reg <= data_out_next;
         busy_reg     <= busy_next;
         ack_reg      <= ack_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      inh_cnt_next  = inh_cnt_reg;
      to_cnt_next   = to_cnt_reg;
      clk_out_next  = clk_out_reg;
      data_out_next = data_out_reg;
      busy_next     = busy_reg;
      ack_next      = 1'b0;
      err_next      = 1'b0;
      supervised    = 1'b0;

      unique case (state_reg)
         ST_IDLE: begin
            clk_out_next  = 1'b1;
            data_out_next = 1'b1;
            busy_next     = 1'b0;
            if (tx_start) begin
               shift_next   = ps2_frame(tx_data);
               inh_cnt_next = '0;
               clk_out_next = 1'b0;
               busy_next    = 1'b1;
               state_next   = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (ce_6mp) begin
               if (inh_cnt_reg == INH_LAST) begin
                  data_out_next = 1'b0;
                  to_cnt_next   = '0;
                  state_next    = ST_RTS;
               end else if (inh_cnt_reg != '1) begin
                  inh_cnt_next = inh_cnt_reg + 1'b1;
               end
            end
         end

         // The timeout window opens on RTS entry, so the release tick already counts.
         ST_RTS: begin
            supervised = 1'b1;
            if (ce_6mp) begin
               clk_out_next = 1'b1;
               bit_cnt_next = '0;
               state_next   = ST_BITS;
            end
         end

         ST_BITS: begin
            supervised = 1'b1;
            if (clk_fall) begin
               data_out_next = shift_reg[0];
               shift_next    = {1'b1, shift_reg[FRAME_W-1:1]};
               bit_cnt_next  = bit_cnt_reg + 1'b1;
               if (bit_cnt_reg == 4'd9) begin
                  state_next = ST_ACK;
               end
            end
         end

         ST_ACK: begin
            supervised = 1'b1;
            if (clk_fall) begin
               if (!data_sync) begin
                  state_next = ST_WAITREL;
               end else begin
                  clk_out_next  = 1'b1;
                  data_out_next = 1'b1;
                  busy_next     = 1'b0;
                  err_next      = 1'b1;
                  state_next    = ST_ERR;
               end
            end
         end

         ST_WAITREL: begin
            supervised = 1'b1;
            if (clk_sync && data_sync) begin
               busy_next  = 1'b0;
               ack_next   = 1'b1;
               state_next = ST_IDLE;
            end
         end

         ST_ERR: begin
            clk_out_next  = 1'b1;
            data_out_next = 1'b1;
            busy_next     = 1'b0;
            state_next    = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Timeout overrides whatever the bus did in the same cycle.
      if (supervised && ce_6mp) begin
         if (to_cnt_reg != '1) begin
            to_cnt_next = to_cnt_reg + 1'b1;
         end
         if (to_cnt_reg == TO_LAST) begin
            clk_out_next  = 1'b1;
            data_out_next = 1'b1;
            busy_next     = 1'b0;
            ack_next      = 1'b0;
            err_next      = 1'b1;
            state_next    = ST_ERR;
         end
      end
   end

   assign ps2_clk_out  = clk_out_reg;
   assign ps2_data_out = data_out_reg;
   assign busy         = busy_reg;
   assign tx_ack       = ack_reg;
   assign tx_err       = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM on a wired-AND bus, randomized command bytes and
// ACK behaviour, scoreboard queues checked by an independent monitor.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 30;
   localparam int TO   = 1500;
   localparam int HALF = 8;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       ce_6mp = 1'b0;
   logic       ps2_clk_out, ps2_data_out;
   logic       clk_line, data_line;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       busy, tx_ack, tx_err;

   int errors = 0;
   int checks = 0;
   int tx_num = 0;

   logic [10:0] exp_frame_q[$];
   logic [10:0] rx_q[$];
   bit          exp_resp_q[$];

   assign clk_line  = ps2_clk_out & dev_clk;
   assign data_line = ps2_data_out & dev_data;

   ps2_host_tx #(.INHIBIT_TICKS(INH), .TIMEOUT_TICKS(TO)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ce_6mp       (ce_6mp),
      .ps2_clk_in   (clk_line),
      .ps2_data_in  (data_line),
      .ps2_clk_out  (ps2_clk_out),
      .ps2_data_out (ps2_data_out),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .busy         (busy),
      .tx_ack       (tx_ack),
      .tx_err       (tx_err)
   );

   always #5 clk_sys = ~clk_sys;

   initial forever begin
      @(posedge clk_sys);
      #1 ce_6mp = ($urandom_range(0, 9) < 6);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame as the device sees it: start, D0..D7, odd parity, stop.
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      f[9]  = ($countones(d) % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // Monitor: compares each response pulse and each captured frame with the scoreboard.
   initial forever begin
      @(negedge clk_sys);
      if (!reset && (tx_ack || tx_err)) begin
         tx_num++;
         if (exp_resp_q.size() == 0) begin
            check("unexpected_pulse", int'({tx_ack, tx_err}), 0);
         end else begin
            bit r;
            r = exp_resp_q.pop_front();
            $display("tx %0d: response %s (expected %s)", tx_num,
                     tx_ack ? "ack" : "err", r ? "ack" : "err");
            check("response", int'({tx_ack, tx_err}), r ? 2 : 1);
            check("busy_at_pulse", int'(busy), 0);
            check("lines_at_pulse", int'({ps2_clk_out, ps2_data_out}), 3);
         end
      end
      if (rx_q.size() > 0) begin
         logic [10:0] got;
         got = rx_q.pop_front();
         if (exp_frame_q.size() == 0) check("unexpected_frame", int'(got), 0);
         else check("frame", int'(got), int'(exp_frame_q.pop_front()));
      end
   end

   task automatic start_tx(input logic [7:0] d);
      @(negedge clk_sys);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk_sys);
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
      check("busy_on_accept", int'(busy), 1);
   endtask

   // Counts ce ticks with clock held low until the start bit appears.
   task automatic wait_rts(output int inh, output bit ok);
      inh = 0;
      ok  = 1'b0;
      for (int i = 0; i < INH * 10 + 50; i++) begin
         if (!ps2_data_out) begin
            ok = 1'b1;
            break;
         end
         if (ce_6mp && !ps2_clk_out) inh++;
         @(negedge clk_sys);
      end
      if (!ok) check("rts_reached", 0, 1);
      else check("clk_low_at_rts", int'(ps2_clk_out), 0);
   endtask

   task automatic bfm_frame(input int n_clk, input bit ack_ok);
      logic [10:0] bits;
      bit seen;
      bits = '0;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_sys);
         if (clk_line && !data_line) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check("bfm_release_seen", 0, 1);
         return;
      end
      bits[0] = data_line;
      for (int k = 1; k <= n_clk; k++) begin
         if (k == 11 && ack_ok) dev_data = 1'b0;
         repeat (HALF) @(negedge clk_sys);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk_sys);
         if (k <= 10) bits[k] = data_line;
         dev_clk = 1'b1;
      end
      if (n_clk == 11) begin
         repeat (2) @(negedge clk_sys);
         dev_data = 1'b1;
         rx_q.push_back(bits);
      end
   endtask

   task automatic wait_pulse();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_sys);
         if (tx_ack || tx_err) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("pulse_seen", 0, 1);
         if (exp_resp_q.size() > 0) void'(exp_resp_q.pop_front());
      end
   endtask

   task automatic run_tx(input logic [7:0] d, input bit ack_ok, input bit poke);
      int inh;
      bit ok;
      start_tx(d);
      exp_frame_q.push_back(ref_frame(d));
      exp_resp_q.push_back(ack_ok);
      wait_rts(inh, ok);
      check("inhibit_ticks", inh, INH);
      if (!ok) begin
         void'(exp_frame_q.pop_back());
         void'(exp_resp_q.pop_back());
         return;
      end
      fork
         bfm_frame(11, ack_ok);
         wait_pulse();
         begin
            if (poke) begin
               repeat (60) @(negedge clk_sys);
               tx_data  = ~d;
               tx_start = 1'b1;
               @(negedge clk_sys);
               tx_start = 1'b0;
               check("busy_after_poke", int'(busy), 1);
            end
         end
      join
   endtask

   task automatic run_timeout(input logic [7:0] d);
      int inh;
      int cnt;
      bit ok;
      bit got;
      start_tx(d);
      exp_resp_q.push_back(1'b0);
      wait_rts(inh, ok);
      check("inhibit_ticks", inh, INH);
      cnt = ce_6mp ? 1 : 0;
      got = 1'b0;
      for (int i = 0; i < TO * 4; i++) begin
         @(negedge clk_sys);
         if (tx_err || tx_ack) begin
            got = 1'b1;
            break;
         end
         if (ce_6mp) cnt++;
      end
      check("timeout_ticks", got ? cnt : -1, TO);
   endtask

   task automatic run_reset_abort(input logic [7:0] d);
      int inh;
      bit ok;
      start_tx(d);
      wait_rts(inh, ok);
      check("inhibit_ticks", inh, INH);
      bfm_frame(4, 1'b1);
      @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      check("abort_lines", int'({ps2_clk_out, ps2_data_out}), 3);
      check("abort_busy", int'(busy), 0);
      check("abort_pulses", int'({tx_ack, tx_err}), 0);
      reset = 1'b0;
      repeat (50) @(negedge clk_sys);
      check("idle_after_abort", int'(busy), 0);
   endtask

   initial begin
      repeat (5) @(negedge clk_sys);
      check("reset_clk_out", int'(ps2_clk_out), 1);
      check("reset_data_out", int'(ps2_data_out), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_pulses", int'({tx_ack, tx_err}), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk_sys);

      run_tx(PS2_CMD_ENABLE, 1'b1, 1'b0);
      run_tx(PS2_CMD_RESET, 1'b1, 1'b0);
      run_tx(PS2_CMD_SETRATE, 1'b0, 1'b0);
      run_timeout(PS2_ACK_BYTE);
      run_reset_abort(8'($urandom));
      run_tx(8'($urandom), 1'b1, 1'b1);
      for (int n = 0; n < 10; n++) begin
         run_tx(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      end

      repeat (20) @(negedge clk_sys);
      check("resp_queue_drained", exp_resp_q.size(), 0);
      check("frame_queue_drained", exp_frame_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
